// File: rtl/fnd_scan_if.sv
// Bus between the FND scan controller and its user/decoder side.
// The master drives the scan controls and digits; the slave drives the decoder signals.
interface fnd_scan_if;
  logic        i_en;
  logic        i_load;
  logic [15:0] i_digits;
  logic        i_lzb;
  logic [1:0]  o_digitSelect;
  logic [3:0]  o_value;
  logic        o_en;
  logic        o_frame;

  modport master (
    output i_en, i_load, i_digits, i_lzb,
    input  o_digitSelect, o_value, o_en, o_frame
  );

  modport slave (
    input  i_en, i_load, i_digits, i_lzb,
    output o_digitSelect, o_value, o_en, o_frame
  );
endinterface

// File: rtl/fnd_scan_controller.sv
// Time-multiplexed 4-digit FND scan controller with blanking gaps, leading-zero
// blanking and a frame-synchronous double buffer for the displayed digits.
module fnd_scan_controller #(
  parameter int SHOW_CYCLES  = 4,
  parameter int BLANK_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  fnd_scan_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHOW,
    ST_BLANK
  } state_t;

  localparam int BLANK_LAST_I = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_LAST_I);

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [1:0]         r_idx, w_idx_nxt;
  logic [15:0]        r_pending, w_pending_nxt;
  logic [15:0]        r_active, w_active_nxt;
  logic               r_pend_valid, w_pend_valid_nxt;
  logic               w_frame_start;
  logic               w_lead_zero;

  logic [1:0]         r_sel, w_sel_nxt;
  logic [3:0]         r_val, w_val_nxt;
  logic               r_en, w_en_nxt;
  logic               r_frame, w_frame_nxt;

  // NOTE: every signal gets a default at the top of always_comb, so no path
  // through the case/if tree can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_idx_nxt        = r_idx;
    w_frame_start    = 1'b0;
    w_pending_nxt    = r_pending;
    w_pend_valid_nxt = r_pend_valid;
    w_active_nxt     = r_active;

    if (!bus.i_en) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
      w_idx_nxt   = '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          w_state_nxt   = ST_SHOW;
          w_cnt_nxt     = '0;
          w_idx_nxt     = '0;
          w_frame_start = 1'b1;
        end
        ST_SHOW: begin
          if (r_cnt == SHOW_LAST) begin
            w_cnt_nxt = '0;
            if (BLANK_CYCLES > 0) begin
              w_state_nxt = ST_BLANK;
            end else begin
              w_state_nxt   = ST_SHOW;
              w_idx_nxt     = r_idx + 2'd1;
              w_frame_start = (r_idx == 2'd3);
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        ST_BLANK: begin
          if (r_cnt == BLANK_LAST) begin
            w_state_nxt   = ST_SHOW;
            w_cnt_nxt     = '0;
            w_idx_nxt     = r_idx + 2'd1;
            w_frame_start = (r_idx == 2'd3);
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
        end
      endcase
    end

    // A load coinciding with the frame start skips the pending buffer entirely.
    if (w_frame_start) begin
      if (bus.i_load) begin
        w_active_nxt = bus.i_digits;
      end else if (r_pend_valid) begin
        w_active_nxt = r_pending;
      end
      w_pend_valid_nxt = 1'b0;
    end else if (bus.i_load) begin
      w_pending_nxt    = bus.i_digits;
      w_pend_valid_nxt = 1'b1;
    end
  end

  always_comb begin
    w_lead_zero = 1'b0;
    unique case (w_idx_nxt)
      2'd1:    w_lead_zero = (w_active_nxt[15:4]  == '0);
      2'd2:    w_lead_zero = (w_active_nxt[15:8]  == '0);
      2'd3:    w_lead_zero = (w_active_nxt[15:12] == '0);
      default: w_lead_zero = 1'b0;
    endcase

    // Outputs are computed from the state being entered, then registered.
    w_sel_nxt   = '0;
    w_val_nxt   = '0;
    w_en_nxt    = 1'b0;
    w_frame_nxt = 1'b0;
    unique case (w_state_nxt)
      ST_SHOW: begin
        w_sel_nxt   = w_idx_nxt;
        w_val_nxt   = w_active_nxt[{w_idx_nxt, 2'b00} +: 4];
        w_en_nxt    = !(bus.i_lzb && w_lead_zero);
        w_frame_nxt = w_frame_start;
      end
      ST_BLANK: begin
        w_sel_nxt = r_sel;
        w_val_nxt = r_val;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_pending    <= '0;
      r_active     <= '0;
      r_pend_valid <= 1'b0;
      r_sel        <= '0;
      r_val        <= '0;
      r_en         <= 1'b0;
      r_frame      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_idx        <= w_idx_nxt;
      r_pending    <= w_pending_nxt;
      r_active     <= w_active_nxt;
      r_pend_valid <= w_pend_valid_nxt;
      r_sel        <= w_sel_nxt;
      r_val        <= w_val_nxt;
      r_en         <= w_en_nxt;
      r_frame      <= w_frame_nxt;
    end
  end

  assign bus.o_digitSelect = r_sel;
  assign bus.o_value       = r_val;
  assign bus.o_en          = r_en;
  assign bus.o_frame       = r_frame;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Bench for fnd_scan_controller: a BLANK=1 and a BLANK=0 build share the same
// stimulus and are compared every cycle against a frame-position model.
module tb_fnd_scan_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, load, lzb;
  logic [15:0] digits;

  int checks   = 0;
  int failures = 0;

  // Model: position within the frame plus the double-buffer contents.
  localparam int SHOW = 4;
  int          per [2] = '{20, 16};
  int          slot[2] = '{5, 4};
  bit          m_run [2];
  int          m_t   [2];
  logic [15:0] m_act [2];
  logic [15:0] m_pend[2];
  bit          m_pv  [2];
  bit          m_lzb;

  fnd_scan_if bus0 ();
  fnd_scan_if bus1 ();

  assign bus0.i_en = en;  assign bus0.i_load = load;
  assign bus0.i_digits = digits;  assign bus0.i_lzb = lzb;
  assign bus1.i_en = en;  assign bus1.i_load = load;
  assign bus1.i_digits = digits;  assign bus1.i_lzb = lzb;

  fnd_scan_controller #(.SHOW_CYCLES(4), .BLANK_CYCLES(1), .CNT_W(16)) dut0 (
    .i_clk(clk), .i_reset(rst), .bus(bus0.slave));
  fnd_scan_controller #(.SHOW_CYCLES(4), .BLANK_CYCLES(0), .CNT_W(16)) dut1 (
    .i_clk(clk), .i_reset(rst), .bus(bus1.slave));

  always #5 clk = ~clk;

  task automatic check(input string tag, input int k, input logic [15:0] obs,
                       input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s dut%0d: observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic model_step();
    bit fs;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_run[k] = 0; m_t[k] = 0; m_act[k] = '0; m_pend[k] = '0; m_pv[k] = 0;
      end else begin
        fs = 0;
        if (!en) begin
          m_run[k] = 0; m_t[k] = 0;
        end else if (!m_run[k]) begin
          m_run[k] = 1; m_t[k] = 0; fs = 1;
        end else begin
          m_t[k] = (m_t[k] + 1) % per[k];
          fs = (m_t[k] == 0);
        end
        if (fs) begin
          if (load) m_act[k] = digits;
          else if (m_pv[k]) m_act[k] = m_pend[k];
          m_pv[k] = 0;
        end else if (load) begin
          m_pend[k] = digits; m_pv[k] = 1;
        end
      end
    end
    m_lzb = lzb;
  endtask

  task automatic check_dut(input int k, input logic [1:0] sel, input logic [3:0] val,
                           input logic oen, input logic fr);
    int d, ph;
    logic [15:0] e_sel, e_val, e_en, e_fr;
    bit blanked;
    e_sel = 0; e_val = 0; e_en = 0; e_fr = 0;
    if (m_run[k]) begin
      d  = m_t[k] / slot[k];
      ph = m_t[k] % slot[k];
      blanked = m_lzb && (d != 0) && ((m_act[k] >> (4 * d)) == 0);
      e_sel = 16'(d);
      e_val = (m_act[k] >> (4 * d)) & 16'hf;
      e_en  = 16'((ph < SHOW) && !blanked);
      e_fr  = 16'(m_t[k] == 0);
    end
    check("digit_select", k, 16'(sel), e_sel);
    check("value",        k, 16'(val), e_val);
    check("dec_en",       k, 16'(oen), e_en);
    check("frame",        k, 16'(fr),  e_fr);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_dut(0, bus0.o_digitSelect, bus0.o_value, bus0.o_en, bus0.o_frame);
    check_dut(1, bus1.o_digitSelect, bus1.o_value, bus1.o_en, bus1.o_frame);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Advance until dut0's displayed position equals pos; a timeout is a failure.
  task automatic wait_pos(input int pos, input string tag);
    for (int n = 0; n < 64 && !(m_run[0] && m_t[0] == pos); n++) cycle();
    check(tag, 0, 16'(m_run[0] && m_t[0] == pos), 16'd1);
  endtask

  initial begin
    rst = 1; en = 0; load = 0; lzb = 0; digits = '0;
    run(3);

    // Free-running scan with all-zero digits.
    rst = 0; en = 1;
    run(45);

    // Load while idle, then enable.
    en = 0; load = 1; digits = 16'h4321;
    cycle();
    load = 0;
    run(2);
    en = 1;
    run(25);

    // Mid-frame load at digit 1 only appears from the next frame.
    wait_pos(5, "wait_digit1");
    load = 1; digits = 16'h9876;
    cycle();
    load = 0;
    run(30);

    // Load coincident with the frame-start edge goes straight to active.
    wait_pos(19, "wait_frame_end");
    load = 1; digits = 16'(32'h0000_a5c3 ^ ($urandom & 32'h0000_0f0f));
    cycle();
    load = 0;
    run(22);

    // Leading-zero blanking.
    lzb = 1; load = 1; digits = 16'h0050;
    cycle();
    load = 0;
    run(42);
    load = 1; digits = 16'h0000;
    cycle();
    load = 0;
    run(42);

    // Randomized traffic including rare resets and enable drops.
    for (int i = 0; i < 300; i++) begin
      rst  = ($urandom % 80) == 0;
      en   = ($urandom % 20) != 0;
      load = ($urandom % 6) == 0;
      for (int j = 0; j < 4; j++)
        digits[4*j +: 4] = ($urandom % 2) ? 4'($urandom % 16) : 4'h0;
      if (($urandom % 10) == 0) lzb = ~lzb;
      cycle();
    end
    rst = 0; en = 1; load = 0; lzb = 0;
    run(5);

    // Drop enable during digit 2 blank, re-enable, then reset mid-SHOW.
    wait_pos(14, "wait_blank2");
    en = 0;
    cycle();
    en = 1;
    run(8);
    load = 1; digits = 16'h1234;
    cycle();
    load = 0;
    wait_pos(6, "wait_show1");
    rst = 1;
    cycle();
    rst = 0;
    run(25);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
